// File: rtl/ptv_machine.sv
// Parking-ticket vending machine: accumulates coin credit and pulses
// a registered one-cycle ticket output; excess credit carries forward.
module ptv_machine #(
   parameter int unsigned COIN_A_VALUE = 5,
   parameter int unsigned COIN_B_VALUE = 10,
   parameter int unsigned PRICE        = 20,
   parameter int unsigned CREDIT_W     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] in,
   output logic       out
);

   localparam logic [CREDIT_W-1:0] A_V = CREDIT_W'(COIN_A_VALUE);
   localparam logic [CREDIT_W-1:0] B_V = CREDIT_W'(COIN_B_VALUE);
   localparam logic [CREDIT_W-1:0] P_V = CREDIT_W'(PRICE);

   logic [CREDIT_W-1:0] credit;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] sum;
   logic                paid;

   // Code 11 is treated as no coin.
   always_comb begin
      coin_val = '0;
      unique case (in)
         2'b01:   coin_val = A_V;
         2'b10:   coin_val = B_V;
         default: coin_val = '0;
      endcase
   end

   assign sum  = credit + coin_val;
   assign paid = (sum >= P_V);

   always_ff @(posedge clk) begin
      if (rst) begin
         credit <= '0;
         out    <= 1'b0;
      end else if (paid) begin
         credit <= sum - P_V;
         out    <= 1'b1;
      end else begin
         credit <= sum;
         out    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ptv_machine.sv
// Self-checking bench for ptv_machine: directed plan plus random coins
// against a running-total reference model.
module tb_ptv_machine;

   localparam int PRICE = 20;
   localparam int VA    = 5;
   localparam int VB    = 10;

   logic       clk;
   logic       rst;
   logic [1:0] in;
   logic       out;

   int ncmp;
   int nerr;
   int total;
   logic exp_out;

   ptv_machine dut (
      .clk(clk),
      .rst(rst),
      .in (in),
      .out(out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int coin_value(input logic [1:0] c);
      if (c == 2'b01) return VA;
      if (c == 2'b10) return VB;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: a ticket is due whenever the running total since reset
   // crosses another multiple of PRICE; credit is the remainder.
   task automatic step(input logic [1:0] c, input logic r);
      int old;
      in  = c;
      rst = r;
      @(posedge clk);
      if (r) begin
         total   = 0;
         exp_out = 1'b0;
      end else begin
         old     = total;
         total   = total + coin_value(c);
         exp_out = ((total / PRICE) != (old / PRICE));
      end
      #1;
      check("out", {31'b0, out}, {31'b0, exp_out});
      check("credit", 32'(dut.credit), 32'(total % PRICE));
   endtask

   initial begin
      ncmp    = 0;
      nerr    = 0;
      total   = 0;
      exp_out = 1'b0;
      rst     = 1'b1;
      in      = 2'b01;

      step(2'b01, 1'b1);
      step(2'b01, 1'b1);
      step(2'b01, 1'b0);

      step(2'b00, 1'b1);
      repeat (4) step(2'b01, 1'b0);
      step(2'b00, 1'b0);

      step(2'b10, 1'b0);
      step(2'b10, 1'b0);
      repeat (4) step(2'b10, 1'b0);

      step(2'b10, 1'b0);
      step(2'b01, 1'b0);
      step(2'b10, 1'b0);
      step(2'b01, 1'b0);
      step(2'b10, 1'b0);

      step(2'b10, 1'b0);
      repeat (5) step(2'b11, 1'b0);
      step(2'b10, 1'b0);

      step(2'b10, 1'b0);
      step(2'b01, 1'b0);
      step(2'b01, 1'b1);
      step(2'b10, 1'b0);
      step(2'b10, 1'b0);

      for (int i = 0; i < 400; i++) begin
         step(2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
